// File: rtl/apb_acc_if.sv
// APB bus bundle between the peripheral bus master and the accelerator front-end.
interface apb_acc_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_acc_ctrl.sv
// APB front-end for the matrix accelerator: A/B operand and R result buffers,
// control/status/cycle registers, and the start/busy/done/abort sequencer.
module apb_acc_ctrl #(
  parameter  int APB_ADDR_WIDTH = 12,
  parameter  int NUM_WORDS      = 256,
  localparam int WIDX           = $clog2(NUM_WORDS)
) (
  input  logic            HCLK,
  input  logic            HRESET,
  apb_acc_if.slave        apb,
  output logic            irq,
  output logic            core_start,
  input  logic            core_done,
  input  logic [WIDX-1:0] core_rd_addr,
  output logic [31:0]     core_rd_a,
  output logic [31:0]     core_rd_b,
  input  logic            core_wr_en,
  input  logic [WIDX-1:0] core_wr_addr,
  input  logic [31:0]     core_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  state_t state, state_nx;

  logic [1:0]      region;
  logic [WIDX-1:0] widx;
  logic            acc, busy, reg_hit, buf_hit;
  logic            ctrl_wr, stat_wr, start_req, abort_req;
  logic            buf_wr, rd_first, rd_pend;
  logic            irq_en, done, err;
  logic [31:0]     cycles;
  logic            done_set, err_set, run_clr;
  logic            r_we;
  logic [WIDX-1:0] r_waddr;
  logic [31:0]     r_wdata;
  logic [31:0]     buf_q;
  logic [31:0]     prdata;

  logic [31:0] mem_a [NUM_WORDS];
  logic [31:0] mem_b [NUM_WORDS];
  logic [31:0] mem_r [NUM_WORDS];

  // Byte-lane bits and any address bits above the region field are don't-care.
  wire unused_addr = &{1'b0, apb.PADDR};

  assign region  = apb.PADDR[WIDX+3:WIDX+2];
  assign widx    = apb.PADDR[WIDX+1:2];
  assign acc     = apb.PSEL & apb.PENABLE;
  assign busy    = (state != S_IDLE);
  assign reg_hit = (region == 2'd0);
  assign buf_hit = ~reg_hit;

  assign ctrl_wr   = acc & apb.PWRITE & reg_hit & (widx == WIDX'(0));
  assign stat_wr   = acc & apb.PWRITE & reg_hit & (widx == WIDX'(1));
  assign start_req = ctrl_wr & apb.PWDATA[0];
  assign abort_req = ctrl_wr & apb.PWDATA[2];

  assign buf_wr   = acc & apb.PWRITE & buf_hit & ~busy;
  // First cycle of a legal buffer read: fetch into buf_q, hold PREADY low.
  assign rd_first = acc & ~apb.PWRITE & buf_hit & ~busy & ~rd_pend;

  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    err_set  = 1'b0;
    run_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          state_nx = S_START;
          run_clr  = 1'b1;
        end
      end
      S_START: begin
        err_set = start_req | abort_req;
        state_nx = abort_req ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        err_set = start_req | abort_req;
        // Abort outranks a coincident completion.
        if (abort_req) begin
          state_nx = S_IDLE;
        end else if (core_done) begin
          state_nx = S_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      irq_en  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cycles  <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_first;
      if (ctrl_wr) irq_en <= apb.PWDATA[1];
      // Hardware set takes priority over software write-1-to-clear.
      done <= done_set | (done & ~(stat_wr & apb.PWDATA[1]) & ~run_clr);
      err  <= err_set  | (err  & ~(stat_wr & apb.PWDATA[2]));
      if (run_clr)
        cycles <= '0;
      else if (state == S_BUSY && cycles != 32'hFFFF_FFFF)
        cycles <= cycles + 32'd1;
    end
  end

  // APB writes to R only happen when idle, core writes only in BUSY: one port suffices.
  always_comb begin
    r_we    = 1'b0;
    r_waddr = widx;
    r_wdata = apb.PWDATA;
    if (state == S_BUSY && core_wr_en) begin
      r_we    = 1'b1;
      r_waddr = core_wr_addr;
      r_wdata = core_wr_data;
    end else if (buf_wr && region == 2'd3) begin
      r_we = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (buf_wr && region == 2'd1) mem_a[widx] <= apb.PWDATA;
    if (buf_wr && region == 2'd2) mem_b[widx] <= apb.PWDATA;
    if (r_we) mem_r[r_waddr] <= r_wdata;
    if (rd_first) begin
      case (region)
        2'd1:    buf_q <= mem_a[widx];
        2'd2:    buf_q <= mem_b[widx];
        default: buf_q <= mem_r[widx];
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      core_rd_a <= '0;
      core_rd_b <= '0;
    end else begin
      core_rd_a <= mem_a[core_rd_addr];
      core_rd_b <= mem_b[core_rd_addr];
    end
  end

  always_comb begin
    prdata = '0;
    if (acc && !apb.PWRITE) begin
      if (reg_hit) begin
        if (widx == WIDX'(0))      prdata = {29'd0, 1'b0, irq_en, 1'b0};
        else if (widx == WIDX'(1)) prdata = {29'd0, err, done, busy};
        else if (widx == WIDX'(2)) prdata = cycles;
      end else if (rd_pend) begin
        prdata = buf_q;
      end
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = ~rd_first;
  assign apb.PSLVERR = acc & buf_hit & busy & ~rd_pend;
  assign irq         = done & irq_en;
  assign core_start  = (state == S_START);

endmodule

// File: tb/tb_apb_acc_ctrl.sv
// Directed bench for apb_acc_ctrl: register/buffer access, run sequencing, abort, reset.
module tb_apb_acc_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        irq, core_start, core_done;
  logic [7:0]  core_rd_addr;
  logic [31:0] core_rd_a, core_rd_b;
  logic        core_wr_en;
  logic [7:0]  core_wr_addr;
  logic [31:0] core_wr_data;

  int checks = 0;
  int failures = 0;

  apb_acc_if #(.ADDR_W(12)) apb ();

  apb_acc_ctrl #(.APB_ADDR_WIDTH(12), .NUM_WORDS(256)) dut (
    .HCLK(clk), .HRESET(rst), .apb(apb),
    .irq(irq), .core_start(core_start), .core_done(core_done),
    .core_rd_addr(core_rd_addr), .core_rd_a(core_rd_a), .core_rd_b(core_rd_b),
    .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data)
  );

  always #5 clk = ~clk;

  // One APB transfer; optionally pulses core_done in the access cycle.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                          input logic pulse_done,
                          output logic [31:0] rd, output int waits, output logic err);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wd;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    core_done = pulse_done;
    waits = 0;
    forever begin
      @(negedge clk);
      if (apb.PREADY) break;
      waits++;
      if (waits > 8) begin
        checks++; failures++;
        $display("FAIL apb_timeout addr=%h", addr);
        break;
      end
      @(posedge clk); #1;
    end
    rd = apb.PRDATA; err = apb.PSLVERR;
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; int w; logic e;
    @(negedge clk);
    checks++; if ({apb.PRDATA, apb.PREADY, apb.PSLVERR, irq, core_start} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_outputs got=%h/%b/%b/%b/%b", apb.PRDATA, apb.PREADY, apb.PSLVERR, irq, core_start); end
    checks++; if ({core_rd_a, core_rd_b} !== 64'h0) begin
      failures++; $display("FAIL reset_core_rd got=%h/%h exp=0", core_rd_a, core_rd_b); end
    @(posedge clk); #1; rst = 1'b0;
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h0 || w !== 0 || e !== 1'b0) begin
      failures++; $display("FAIL reset_status got=%h w=%0d e=%b exp=0 w=0", rd, w, e); end
    apb_xfer(1'b0, 12'h008, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h0 || w !== 0) begin
      failures++; $display("FAIL reset_cycles got=%h w=%0d exp=0 w=0", rd, w); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_buffers;
    logic [31:0] rd; int w; logic e;
    apb_xfer(1'b1, 12'h400, 32'h04030201, 1'b0, rd, w, e);
    checks++; if (w !== 0 || e !== 1'b0) begin failures++; $display("FAIL buf_wr_a w=%0d e=%b exp=0/0", w, e); end
    apb_xfer(1'b1, 12'hBFC, 32'hDEADBEEF, 1'b0, rd, w, e);
    apb_xfer(1'b0, 12'h400, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h04030201 || w !== 1 || e !== 1'b0) begin
      failures++; $display("FAIL buf_rd_a got=%h w=%0d exp=04030201 w=1", rd, w); end
    apb_xfer(1'b0, 12'hBFC, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'hDEADBEEF || w !== 1) begin
      failures++; $display("FAIL buf_rd_b got=%h w=%0d exp=deadbeef w=1", rd, w); end
    core_rd_addr = 8'd0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (core_rd_a !== 32'h04030201) begin
      failures++; $display("FAIL core_rd_a got=%h exp=04030201", core_rd_a); end
    core_rd_addr = 8'd255;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (core_rd_b !== 32'hDEADBEEF) begin
      failures++; $display("FAIL core_rd_b got=%h exp=deadbeef", core_rd_b); end
  endtask

  task automatic test_run;
    logic [31:0] rd; int w; logic e; int pulses;
    apb_xfer(1'b1, 12'h000, 32'h3, 1'b0, rd, w, e);
    pulses = 0;
    @(negedge clk); if (core_start) pulses++;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      core_wr_en = (i == 5); core_wr_addr = 8'd5; core_wr_data = 32'h1337;
      core_done = (i == 10);
      @(negedge clk); if (core_start) pulses++;
    end
    @(posedge clk); #1; core_done = 1'b0; core_wr_en = 1'b0;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL start_pulses got=%0d exp=1", pulses); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL run_irq got=%b exp=1", irq); end
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL run_status got=%h exp=2", rd); end
    apb_xfer(1'b0, 12'h008, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'd10) begin failures++; $display("FAIL run_cycles got=%0d exp=10", rd); end
    apb_xfer(1'b0, 12'h000, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL run_ctrl got=%h exp=2", rd); end
    apb_xfer(1'b0, 12'hC14, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h1337 || w !== 1) begin
      failures++; $display("FAIL run_r5 got=%h w=%0d exp=1337 w=1", rd, w); end
    apb_xfer(1'b1, 12'h004, 32'h2, 1'b0, rd, w, e);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq got=%b exp=0", irq); end
  endtask

  task automatic test_busy_access;
    logic [31:0] rd; int w; logic e;
    apb_xfer(1'b1, 12'h000, 32'h1, 1'b0, rd, w, e);
    apb_xfer(1'b1, 12'h400, 32'hFFFFFFFF, 1'b0, rd, w, e);
    checks++; if (e !== 1'b1 || w !== 0) begin failures++; $display("FAIL busy_wr_err got=%b w=%0d exp=1 w=0", e, w); end
    apb_xfer(1'b0, 12'hC00, 32'h0, 1'b0, rd, w, e);
    checks++; if (e !== 1'b1 || rd !== 32'h0 || w !== 0) begin
      failures++; $display("FAIL busy_rd_err got=%b rd=%h w=%0d exp=1 rd=0 w=0", e, rd, w); end
    apb_xfer(1'b1, 12'h000, 32'h1, 1'b0, rd, w, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL restart_slverr got=%b exp=0", e); end
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h5) begin failures++; $display("FAIL busy_status got=%h exp=5", rd); end
    @(posedge clk); #1; core_done = 1'b1;
    @(posedge clk); #1; core_done = 1'b0;
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h6) begin failures++; $display("FAIL post_busy_status got=%h exp=6", rd); end
    apb_xfer(1'b0, 12'h400, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h04030201) begin failures++; $display("FAIL a_unchanged got=%h exp=04030201", rd); end
    apb_xfer(1'b1, 12'h004, 32'h6, 1'b0, rd, w, e);
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_both got=%h exp=0", rd); end
  endtask

  task automatic test_abort;
    logic [31:0] rd; int w; logic e;
    apb_xfer(1'b1, 12'h000, 32'h3, 1'b0, rd, w, e);
    repeat (3) @(posedge clk);
    #1;
    apb_xfer(1'b1, 12'h000, 32'h6, 1'b1, rd, w, e);
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL abort_status got=%h exp=4", rd); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL abort_irq got=%b exp=0", irq); end
    apb_xfer(1'b1, 12'h004, 32'h4, 1'b0, rd, w, e);
    apb_xfer(1'b1, 12'h000, 32'h4, 1'b0, rd, w, e);
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL idle_abort got=%h exp=0", rd); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] rd; int w; logic e;
    apb_xfer(1'b1, 12'h000, 32'h3, 1'b0, rd, w, e);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    checks++; if ({apb.PRDATA, apb.PREADY, apb.PSLVERR, irq, core_start, core_rd_a, core_rd_b} !==
                  {32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      failures++; $display("FAIL midrun_reset_outputs got=%h/%b/%b/%b/%b/%h/%h", apb.PRDATA, apb.PREADY,
                           apb.PSLVERR, irq, core_start, core_rd_a, core_rd_b); end
    @(posedge clk); #1; rst = 1'b0;
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midrun_status got=%h exp=0", rd); end
    apb_xfer(1'b1, 12'h000, 32'h1, 1'b0, rd, w, e);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1; core_done = (i == 3);
    end
    @(posedge clk); #1; core_done = 1'b0;
    apb_xfer(1'b0, 12'h004, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL rerun_status got=%h exp=2", rd); end
    apb_xfer(1'b0, 12'h008, 32'h0, 1'b0, rd, w, e);
    checks++; if (rd !== 32'd3) begin failures++; $display("FAIL rerun_cycles got=%0d exp=3", rd); end
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    core_done = 1'b0; core_rd_addr = '0; core_wr_en = 1'b0; core_wr_addr = '0; core_wr_data = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_buffers();
    test_run();
    test_busy_access();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_acc_ctrl.md
# apb_acc_ctrl

Parametrised APB slave front-end for the matrix accelerator. It holds two operand buffers (A, B) and one result buffer (R) of `NUM_WORDS` 32-bit words each, plus control, status and cycle-count registers. It sequences the core through a start/busy/done handshake with abort, error reporting and a level interrupt. It sits between the peripheral APB bus and the accelerator core, replacing the fixed 8-byte hand-decoded window with full, parametrised buffer windows.

## Interface
- `APB_ADDR_WIDTH`, 12: APB address width; must be ≥ WIDX+4.
- `NUM_WORDS`, 256: words per buffer, power of two. WIDX = $clog2(NUM_WORDS).
- `HCLK` in 1: the single clock; all logic on its rising edge.
- `HRESET` in 1: asynchronous, active-high reset.
- `PADDR` in APB_ADDR_WIDTH: byte address; bits [1:0] ignored.
- `PWDATA` in 32: APB write data.
- `PWRITE` in 1: APB write (1) or read (0).
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PRDATA` out 32: read data, valid when PREADY=1.
- `PREADY` out 1: transfer complete.
- `PSLVERR` out 1: transfer error, valid when PREADY=1.
- `irq` out 1: level interrupt, = STATUS.done & CTRL.irq_en.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_rd_addr` in WIDX: operand word index.
- `core_rd_a` out 32: A[core_rd_addr], registered, 1-cycle latency.
- `core_rd_b` out 32: B[core_rd_addr], registered, 1-cycle latency.
- `core_wr_en` in 1: result write strobe.
- `core_wr_addr` in WIDX: result word index.
- `core_wr_data` in 32: result data.

## Operation
- Region select is PADDR[WIDX+3:WIDX+2]; word index is PADDR[WIDX+1:2]. Region 0 = registers, 1 = A, 2 = B, 3 = R. With defaults: A at 0x400, B at 0x800, R at 0xC00.
- Registers, at word indices 0..2:
  - CTRL (0x0), RW: bit0 start, write-1-pulse, reads 0. bit1 irq_en. bit2 abort, write-1-pulse, reads 0.
  - STATUS (0x4): bit0 busy (RO). bit1 done (sticky, write-1-to-clear). bit2 err (sticky, write-1-to-clear).
  - CYCLES (0x8), RO: cycles spent in BUSY for the last or current run.
  - Other register indices read 0; writes to them are ignored, with no error.
- FSM states IDLE, START, BUSY:
  - IDLE→START on a CTRL write with bit0=1. This clears CYCLES and STATUS.done.
  - START: core_start=1 for exactly one cycle, then →BUSY.
  - BUSY→IDLE on core_done=1. Sets STATUS.done.
  - BUSY→IDLE on a CTRL write with bit2=1 (abort). Sets STATUS.err; done is not set.
- STATUS.busy = 1 in START and BUSY.
- CYCLES increments by 1 each BUSY cycle and saturates at 0xFFFFFFFF.
- Buffer access rules:
  - APB reads/writes to A, B and R are allowed only when busy=0. Otherwise PSLVERR=1, writes are dropped and PRDATA=0.
  - The core port writes R only while in BUSY; core_wr_en outside BUSY is ignored.
  - core_rd_a/b update every cycle regardless of state.
- Boundary cases:
  - Start while busy: ignored, sets err, PSLVERR=0.
  - core_done in IDLE or START: ignored.
  - Abort and core_done in the same cycle: abort wins (err=1, done=0).
  - Abort in IDLE: no effect.
  - Hardware set and software W1C of done/err in the same cycle: set wins.
- Buffers are not reset; their contents after HRESET are undefined.

## Timing
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, irq=0, core_start=0, core_rd_a=0, core_rd_b=0. CTRL, STATUS and CYCLES are 0; FSM is in IDLE.
- HRESET mid-run forces IDLE immediately. No done or err is set, and core_start is deasserted.
- Register access, and any access returning PSLVERR: zero wait states. PREADY=1 in the first access cycle.
- Buffer writes: zero wait states; the RAM is written at the end of the access cycle.
- Buffer reads: one wait state. PREADY=0 in the first access cycle and 1 in the second, with PRDATA registered.
- A CTRL start write in cycle N gives core_start=1 in N+1 and busy=1 from N+1.
- core_done in cycle M gives busy=0 and done=1 from M+1; irq=1 from M+1 if irq_en.
- A core_wr_en write in cycle K is readable over APB once busy=0.

## Test plan
- Reset then read STATUS and CYCLES: both read 0x0 with zero waits; irq=0.
- Write A[0]=0x04030201 and B[255]=0xDEADBEEF, then read both back. Expect the same values, one wait state each, and core_rd_a=0x04030201 one cycle after core_rd_addr=0.
- Write CTRL=0x3, model core_done 10 cycles after core_start, with a core write R[5]=0x1337 during the run. Expect a single core_start pulse, STATUS=0x2, CYCLES=10, irq=1, and R[5] reading 0x1337. Then W1C done: irq→0.
- While busy: an APB write to A and a read of R each give PSLVERR=1 with A unchanged; a second start sets STATUS.err.
- Write CTRL abort in the same cycle as core_done: expect STATUS=0x4 (err only), busy=0, irq=0.
- Assert HRESET during BUSY: all outputs return to their reset values and FSM=IDLE; a subsequent start runs normally.
